mem_access_unit: RTL and testbench

//  Initiator for the 256x32 word RAM port (addr/rw/en/d_in/d_out). Accepts byte/half/word

---
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator for a 256x32 word RAM port. Takes byte/half/word load and store
//   requests from the core MEM stage over a valid/ready handshake, issues the
//   RAM cycles, and answers each request with one response. Loads are sign- or
//   zero-extended. Sub-word stores are done as read-modify-write. Misaligned,
//   illegal-size and out-of-range requests get an error response and never
//   touch the RAM.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_signed        loads: 1 = sign-extend, 0 = zero-extend
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   resp_valid/ready  response handshake
//   resp_rdata        extended load result, 0 for stores and faults
//   resp_err          request faulted, no RAM access made
//   ram_addr          word-aligned RAM address
//   ram_rw, ram_en    RAM write strobe and enable
//   ram_wdata         RAM write data
//   ram_rdata         RAM combinational read data (valid only while reading)
module mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_addr,
    output logic        ram_rw,
    output logic        ram_en,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        sgn_q, sgn_d;
    logic [31:0] data_q, data_d;    // store data, becomes the merged word after RD
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_fault;

    // Pick the addressed lane out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay right-aligned store data onto its lane, keeping the other bytes.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    assign req_fault = (req_size == 2'b11)
                    || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                    || (req_addr >= MEM_LIMIT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[31:2], 2'b00};
                    lane_d  = req_addr[1:0];
                    size_d  = req_size;
                    we_d    = req_we;
                    sgn_d   = req_signed;
                    data_d  = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = req_fault;
                    if (req_fault)
                        state_d = S_RESP;
                    else if (req_we && req_size == 2'b10)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            // ram_rdata is only looked at here, on the edge closing the read.
            S_RD: begin
                if (we_q) begin
                    data_d  = store_merge(ram_rdata, data_q, lane_q, size_q);
                    state_d = S_WR;
                end else begin
                    rdata_d = load_extend(ram_rdata, lane_q, size_q, sgn_q);
                    state_d = S_RESP;
                end
            end
            S_WR: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Datapath registers carry no reset; every output is gated by state.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        lane_q  <= lane_d;
        size_q  <= size_d;
        we_q    <= we_d;
        sgn_q   <= sgn_d;
        data_q  <= data_d;
        rdata_q <= rdata_d;
        err_q   <= err_d;
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign ram_en     = (state_q == S_RD) || (state_q == S_WR);
    assign ram_rw     = (state_q == S_WR);
    assign ram_addr   = ram_en ? addr_q : 32'h0;
    assign ram_wdata  = (state_q == S_WR) ? data_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_rw, ram_en;

    int total = 0;
    int bad   = 0;

    // Word RAM seen by the DUT, and a byte-level reference memory.
    logic [31:0] mem [0:255];
    logic [7:0]  ref_mem [0:1023];

    int          ram_cyc = 0;
    int          wr_cyc  = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err   = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_rw     (ram_rw),
        .ram_en     (ram_en),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM: combinational read; a poison word whenever it is not being read.
    assign ram_rdata = (ram_en && !ram_rw) ? mem[ram_addr[9:2]] : 32'hBAD0BAD0;

    always @(posedge clk)
        if (ram_en && ram_rw)
            mem[ram_addr[9:2]] <= ram_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Bus monitor.
    always @(negedge clk) begin
        if (ram_en) begin
            ram_cyc++;
            last_addr = ram_addr;
            if (ram_rw)
                wr_cyc++;
        end
    end

    // Per-cycle compare against the model's expected response.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (resp_valid)
                chk("resp", 64'({resp_err, resp_rdata}), 64'({exp_err, exp_rdata}));
            if (ram_en)
                chk("ram_ctl", 64'({req_ready, resp_valid, ram_addr[1:0]}), 64'(0));
        end
    end

    function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0)
            || (sz == 2'd2 && a % 4 != 0) || (a >= 32'd1024);
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        case (sz)
            2'd0: begin
                v = {24'h0, ref_mem[a]};
                if (sg && ref_mem[a][7]) v = v - 32'h100;
            end
            2'd1: begin
                v = {16'h0, ref_mem[a+1], ref_mem[a]};
                if (sg && ref_mem[a+1][7]) v = v - 32'h10000;
            end
            default: v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b = (a / 4) * 4;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output logic [31:0] got);
        logic f;
        int   lat, wr, n, c0, w0, nbytes;
        f      = ref_fault(sz, a);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lat    = f ? 0 : (!we ? 1 : (sz == 2'd2 ? 1 : 2));
        wr     = (we && !f) ? 1 : 0;
        exp_err   = f;
        exp_rdata = (!we && !f) ? ref_load(int'(a), sz, sg) : 32'h0;
        c0 = ram_cyc;
        w0 = wr_cyc;
        got = 32'h0;

        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!resp_valid) begin
            chk("resp_timeout", 64'(0), 64'(1));
            return;
        end
        chk("latency", 64'(n), 64'(lat));
        got = resp_rdata;
        repeat (hold) begin
            @(negedge clk);
            chk("bp_ctl", 64'({resp_valid, req_ready, ram_en}), 64'(3'b100));
            chk("bp_hold", 64'(resp_rdata), 64'(got));
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("release", 64'({resp_valid, req_ready}), 64'(2'b01));
        chk("ram_cycles", 64'(ram_cyc - c0), 64'(lat));
        chk("ram_writes", 64'(wr_cyc - w0), 64'(wr));
        if (lat > 0)
            chk("ram_addr", 64'(last_addr), 64'({a[31:2], 2'b00}));
        if (we && !f) begin
            for (int i = 0; i < nbytes; i++)
                ref_mem[int'(a) + i] = wd[8*i +: 8];
            chk("ram_word", 64'(mem[a[9:2]]), 64'(ref_word(int'(a))));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g;
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", 64'({req_ready, resp_valid, resp_err, ram_en, ram_rw}), 64'(5'b10000));
        chk("rst_data", 64'({resp_rdata, ram_addr}), 64'(0));
        chk("rst_wdata", 64'(ram_wdata), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // 1: word store and load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, g);
        chk("t1_store_rdata", 64'(g), 64'(0));
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g);
        chk("t1_load", 64'(g), 64'(32'hDEADBEEF));

        // 2: byte store read-modify-write, signed/unsigned byte loads
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0, g);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFFA5, 0, g);
        chk("t2_word", 64'(mem[4]), 64'(32'hA5223344));
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, g);
        chk("t2_ldb_s", 64'(g), 64'(32'hFFFFFFA5));
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, g);
        chk("t2_ldb_u", 64'(g), 64'(32'h000000A5));
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, g);
        chk("t2_ldb_lane1", 64'(g), 64'(32'h00000033));

        // 3: half store and loads
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h12348001, 0, g);
        chk("t3_word", 64'(mem[8]), 64'(32'h80010000));
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, g);
        chk("t3_ldh_s", 64'(g), 64'(32'hFFFF8001));
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0, g);
        chk("t3_ldh_u", 64'(g), 64'(32'h00008001));
        do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h00007F55, 0, g);
        chk("t3_word_lo", 64'(mem[8]), 64'(32'h80017F55));

        // 4: faults
        do_req(1'b0, 2'd1, 1'b1, 32'h21, 32'h0, 0, g);
        chk("t4_half_odd", 64'(g), 64'(0));
        do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'hCAFEF00D, 0, g);
        chk("t4_word_mis", 64'(mem[1]), 64'(0));
        do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0, g);
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, g);
        do_req(1'b1, 2'd0, 1'b0, 32'h3FF, 32'h5A, 0, g);
        chk("t4_last_byte", 64'(mem[255]), 64'(32'h5A000000));

        // 5: backpressure
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, g);
        chk("t5_load", 64'(g), 64'(32'hA5223344));

        // 6: reset during the write cycle of a byte store
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h31; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("t6_rd", 64'({ram_en, ram_rw}), 64'(2'b10));
        @(posedge clk);
        #1;
        chk("t6_wr", 64'({ram_en, ram_rw}), 64'(2'b11));
        rst = 1'b0;
        @(posedge clk);
        #1;
        w0 = wr_cyc;
        chk("t6_abort", 64'({req_ready, resp_valid, ram_en, resp_err}), 64'(4'b1000));
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_nowrite", 64'(wr_cyc - w0), 64'(0));
        chk("t6_idle", 64'({req_ready, resp_valid, ram_en}), 64'(3'b100));

        // Unit still works after the abort
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, g);
        chk("t6_after", 64'(g), 64'(32'h80017F55));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
